// File: rtl/pipeline_pkg.sv
// Shared pipeline types: bus widths, MEM-stage FSM encoding and the MEM/WB bundle.
package pipeline_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_AW = 5;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_e;

  // Also consumed by writeback_cycle; an all-zero value is a bubble.
  typedef struct packed {
    logic              regwrite;
    logic              resultsrc;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] pcplus4;
    logic [DATA_W-1:0] aluresult;
    logic [DATA_W-1:0] readdata;
  } mem_wb_t;

endpackage

// File: rtl/memory_cycle_if.sv
// Data-memory req/ack bus between the MEM stage (master) and data memory (slave).
interface memory_cycle_if;
  import pipeline_pkg::*;

  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );

endinterface

// File: rtl/memory_cycle_mem_wb_reg.sv
// MEM/WB pipeline register; a bubble or reset loads an all-zero bundle.
module mem_wb_reg
  import pipeline_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    bubble,
  input  mem_wb_t d,
  output mem_wb_t q
);

  always_ff @(posedge clk) begin
    if (!reset || bubble) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/memory_cycle.sv
// MEM stage: runs loads/stores over the req/ack bus, stalls upstream until the
// handshake completes or times out, and feeds the MEM/WB register.
module memory_cycle
  import pipeline_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              regwriteM,
  input  logic              MemWriteM,
  input  logic              ResultSrcM,
  input  logic [REG_AW-1:0] RD_M,
  input  logic [DATA_W-1:0] PCPlus4M,
  input  logic [DATA_W-1:0] WriteDataM,
  input  logic [DATA_W-1:0] ALU_ResultM,
  output logic              StallM,
  memory_cycle_if.master    bus,
  output logic              mem_err,
  output logic              regwriteW,
  output logic              ResultSrcW,
  output logic [REG_AW-1:0] RD_W,
  output logic [DATA_W-1:0] PCPlus4W,
  output logic [DATA_W-1:0] ALU_ResultW,
  output logic [DATA_W-1:0] ReadDataW
);

  localparam logic [7:0] LastWait = 8'(MAX_WAIT - 1);

  mem_state_e        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              err_q, err_d;
  logic              bubble;
  logic              access;
  logic              is_load;
  mem_wb_t           wb_d, wb_q;

  assign access  = MemWriteM | ResultSrcM;
  // A combined store+load flag behaves as a store.
  assign is_load = ResultSrcM & ~MemWriteM;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = 1'b0;
    StallM  = 1'b0;
    bubble  = 1'b1;

    wb_d.regwrite  = regwriteM;
    wb_d.resultsrc = is_load;
    wb_d.rd        = RD_M;
    wb_d.pcplus4   = PCPlus4M;
    wb_d.aluresult = ALU_ResultM;
    wb_d.readdata  = '0;

    unique case (state_q)
      IDLE: begin
        if (access) begin
          StallM  = 1'b1;
          req_d   = 1'b1;
          we_d    = MemWriteM;
          addr_d  = ALU_ResultM & ~DATA_W'(3);
          wdata_d = WriteDataM;
          cnt_d   = '0;
          state_d = ACCESS;
        end else begin
          bubble = 1'b0;
        end
      end
      ACCESS: begin
        if (bus.mem_ack) begin
          // Ack beats a coincident timeout.
          req_d         = 1'b0;
          state_d       = IDLE;
          bubble        = 1'b0;
          wb_d.readdata = is_load ? bus.mem_rdata : '0;
        end else if (cnt_q == LastWait) begin
          req_d   = 1'b0;
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          StallM = 1'b1;
          if (cnt_q != 8'hff) begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  mem_wb_reg u_mem_wb_reg (
    .clk    (clk),
    .reset  (reset),
    .bubble (bubble),
    .d      (wb_d),
    .q      (wb_q)
  );

  assign bus.mem_req   = req_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign mem_err       = err_q;

  assign regwriteW   = wb_q.regwrite;
  assign ResultSrcW  = wb_q.resultsrc;
  assign RD_W        = wb_q.rd;
  assign PCPlus4W    = wb_q.pcplus4;
  assign ALU_ResultW = wb_q.aluresult;
  assign ReadDataW   = wb_q.readdata;

endmodule
